// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    // Controller states: waiting, processing digits, and the one-cycle result pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n digits, never narrower than one bit
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full-adder cells. Besides the sum and carry
// out, it exposes the carry into the top bit so the caller can derive
// signed overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [DIGIT:0] c;

    // Ripple the carry from bit 0 upwards, one full-adder cell per bit
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor. Operands are latched on an
// accepted start, then consumed DIGIT bits per cycle, LSB digit first, with
// the carry held in a register between digits. Subtraction is done as
// A + ~B + 1 by inverting B on entry and seeding the carry with 1.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $fatal(1, "addsub_serial: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_cout;
    logic                   dig_ctop;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                   last_digit;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_top (dig_ctop)
    );

    // New digit enters from the top; the concatenation also covers DIGIT == WIDTH
    assign res_cat    = {dig_sum, res_q};
    assign last_digit = (cnt_q == CW'(N - 1));

    // Next-state and datapath update: accept, shift one digit, or finish
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_ctop ^ dig_cout;
                    zero_d  = (res_d == '0);
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign res  = res_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed vectors and corner sequences on a 16/4
// instance, plus randomized runs on several (WIDTH, DIGIT) instances checked
// against an arithmetic reference model.
module tb_addsub_serial;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 16-bit / 4-bit-digit instance
    logic        rst, start, sub;
    logic [15:0] a, b, res;
    logic        busy, done, cout, ovf, zero;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and sign rules, no carry chains
    function automatic void refModel(input int w, input longint unsigned ra,
                                     input longint unsigned rb, input logic rsub,
                                     output longint unsigned rr, output logic rco,
                                     output logic rov, output logic rz);
        longint unsigned modv = 64'd1 << w;
        logic sa, sb, sr;
        if (!rsub) begin
            rr  = (ra + rb) % modv;
            rco = ((ra + rb) >= modv);
        end else begin
            rr  = (ra + modv - rb) % modv;
            rco = (ra >= rb);
        end
        sa  = ((ra >> (w - 1)) & 64'd1) != 0;
        sb  = ((rb >> (w - 1)) & 64'd1) != 0;
        sr  = ((rr >> (w - 1)) & 64'd1) != 0;
        rov = rsub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        rz  = (rr == 0);
    endfunction

    // Drive one operation from a negedge; optionally poke start mid-run.
    // Returns the negedge index where done appeared (0 if never) and busy count.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic ts, input int inject,
                                 output int lat, output int busy_cycles);
        a = ta;
        b = tb_v;
        sub = ts;
        start = 1'b1;
        lat = 0;
        busy_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                lat = c;
                break;
            end
            if (c == inject) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
                sub = ~ts;
            end
        end
    endtask

    // Randomized parameter sweep, one independent instance per configuration
    localparam int SW_W[4] = '{8, 8, 32, 17};
    localparam int SW_D[4] = '{1, 8, 4, 17};

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = SW_W[g];
        localparam int D = SW_D[g];
        localparam int N = W / D;

        logic         s_rst, s_start, s_sub;
        logic [W-1:0] s_a, s_b, s_res;
        logic         s_busy, s_done, s_cout, s_ovf, s_zero;
        logic         fin = 1'b0;

        addsub_serial #(.WIDTH(W), .DIGIT(D)) dut_sw (
            .clk   (clk),
            .rst   (s_rst),
            .start (s_start),
            .sub   (s_sub),
            .a     (s_a),
            .b     (s_b),
            .busy  (s_busy),
            .done  (s_done),
            .res   (s_res),
            .cout  (s_cout),
            .ovf   (s_ovf),
            .zero  (s_zero)
        );

        // Sequence of random operations, back to back, each checked on done
        initial begin
            longint unsigned er;
            logic eco, eov, ez;
            int lat, bc;
            string tag;
            tag = $sformatf("W%0dD%0d", W, D);
            s_rst = 1'b1;
            s_start = 1'b0;
            s_sub = 1'b0;
            s_a = '0;
            s_b = '0;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                s_a = W'($urandom);
                s_b = W'($urandom);
                s_sub = 1'($urandom);
                if (i == 0) begin s_a = '1; s_b = W'(1); s_sub = 1'b0; end
                if (i == 1) begin s_a = '0; s_a[W-1] = 1'b1; s_b = W'(1); s_sub = 1'b1; end
                if (i == 2) begin s_b = s_a; s_sub = 1'b1; end
                refModel(W, longint'(s_a), longint'(s_b), s_sub, er, eco, eov, ez);
                s_start = 1'b1;
                lat = 0;
                bc = 0;
                for (int c = 1; c <= 64; c++) begin
                    @(negedge clk);
                    s_start = 1'b0;
                    if (s_busy) bc++;
                    if (s_done) begin
                        lat = c;
                        break;
                    end
                end
                checkOutput({tag, "_latency"}, lat, N + 1);
                checkOutput({tag, "_busy"}, bc, N);
                checkOutput({tag, "_res"}, longint'(s_res), er);
                checkOutput({tag, "_cout"}, s_cout, eco);
                checkOutput({tag, "_ovf"}, s_ovf, eov);
                checkOutput({tag, "_zero"}, s_zero, ez);
            end
            fin = 1'b1;
        end
    end

    // Directed tests on the main instance, then wait for the sweep
    initial begin
        vec_t vecs[6];
        int lat, bc, pulses;
        logic all_fin;

        vecs[0] = '{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h00AA, 16'h00AA, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_res", res, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_zero", zero, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, 0, lat, bc);
            checkOutput($sformatf("vec%0d_latency", i), lat, 5);
            checkOutput($sformatf("vec%0d_busy", i), bc, 4);
            checkOutput($sformatf("vec%0d_res", i), res, vecs[i].res);
            checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
            checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            checkOutput($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
        end

        // A start pulse with new operands in RUN cycle 2 must be ignored
        @(negedge clk);
        applyStimulus(16'h1234, 16'h0FF0, 1'b0, 2, lat, bc);
        checkOutput("ignore_latency", lat, 5);
        checkOutput("ignore_busy", bc, 4);
        checkOutput("ignore_res", res, 16'h2224);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_after_done", busy, 0);

        // Back-to-back: second start is presented during the DONE cycle
        applyStimulus(16'h0005, 16'h0007, 1'b1, 0, lat, bc);
        checkOutput("b2b_first_res", res, 16'hFFFE);
        applyStimulus(16'h00AA, 16'h00AA, 1'b1, 0, lat, bc);
        checkOutput("b2b_latency", lat, 5);
        checkOutput("b2b_busy", bc, 4);
        checkOutput("b2b_res", res, 16'h0000);
        checkOutput("b2b_zero", zero, 1);
        checkOutput("b2b_cout", cout, 1);

        // Leave nonzero flags behind, then reset during RUN cycle 2
        applyStimulus(16'h8000, 16'h0001, 1'b1, 0, lat, bc);
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_res", res, 0);
        checkOutput("midrst_cout", cout, 0);
        checkOutput("midrst_ovf", ovf, 0);
        checkOutput("midrst_zero", zero, 0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", pulses, 0);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 0, lat, bc);
        checkOutput("after_rst_latency", lat, 5);
        checkOutput("after_rst_res", res, 16'h3333);

        all_fin = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            all_fin = g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin;
            if (all_fin) break;
            @(negedge clk);
        end
        checkOutput("sweep_finished", all_fin, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial two's-complement adder/subtractor with a start/done handshake and status flags. It processes `DIGIT` bits per clock through a ripple of full-adder cells with a registered carry, so an N-bit add or subtract costs `WIDTH/DIGIT` cycles instead of a `WIDTH`-deep ripple chain. It is intended for datapaths where area matters more than latency, and as a drop-in arithmetic unit behind a simple controller.

## Interface
- `WIDTH`, 16, operand and result width in bits; must be at least 2.
- `DIGIT`, 4, bits processed per cycle. `WIDTH % DIGIT == 0` is required; elaboration-time check, fatal if violated.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request an operation. Sampled only in IDLE or DONE.
- `sub` input 1: 0 selects A+B, 1 selects A−B. Sampled with `start`.
- `a` input WIDTH: operand A. Sampled with `start`.
- `b` input WIDTH: operand B. Sampled with `start`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; result and flags are valid from this cycle.
- `res` output WIDTH: the result. Held until the next accepted `start`.
- `cout` output 1: final carry out. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `ovf` output 1: signed overflow, defined as (carry into MSB) XOR (carry out of MSB).
- `zero` output 1: `res == 0`.

## Operation
- FSM states are IDLE, RUN and DONE. Define N = WIDTH/DIGIT.
- **Accepting a start.** In IDLE or DONE with `start=1`:
  - latch `a` into the A shift register;
  - latch `b ^ {WIDTH{sub}}` into the B shift register;
  - set the carry register to `sub`, the digit counter to 0, and the state to RUN.
- **RUN cycle.** Each cycle:
  - the digit adder sums the low `DIGIT` bits of A and B with the carry register;
  - the sum digit is shifted into `res` from the MSB side, so after N shifts the digits are in order;
  - the A and B registers shift right by `DIGIT`;
  - the carry register takes the digit carry-out;
  - the counter increments.
- **Last RUN cycle** (counter == N−1):
  - also capture `cout` = digit carry-out and `ovf` = carry into bit DIGIT−1 XOR digit carry-out;
  - `zero` is computed from the final `res`;
  - go to DONE.
- **DONE.** `done`=1 for exactly one cycle. Without `start`, go to IDLE. With `start`, accept immediately (back-to-back).
- **start during RUN** is ignored. Operands are not re-sampled and there is no error indication.
- **`res` during RUN** shows partial, shifting contents. Only values at or after `done` are defined. Flags keep their previous values until the last RUN edge.
- **DIGIT == WIDTH:** RUN lasts one cycle.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `res`=0, `cout`=0, `ovf`=0, `zero`=0.
- **Reset mid-operation:** the operation is abandoned, outputs return to their reset values, and `done` is never pulsed for the abandoned operation.

## Timing
- Call the edge that samples `start` edge 0.
- RUN occupies the cycles following edges 0 through N−1. `busy`=1 in those N cycles.
- The result is written at edge N. `done`=1 in the cycle after edge N, so latency is N cycles from acceptance to `done`.
- Throughput with back-to-back starts: one operation per N+1 cycles.
- `rst` overrides `start` in the same cycle.
- Critical path: a DIGIT-bit ripple plus the WIDTH-bit zero-detect in the last RUN cycle.

## Structure
- Shared package `addsub_pkg`:
  - FSM state enum (IDLE, RUN, DONE);
  - function `clog2` for the counter width, `$clog2(N)` with a minimum of 1 bit.
- Sub-module `digit_adder #(DIGIT)`: a combinational ripple of `DIGIT` full-adder cells. Outputs are the sum, the carry out, and the carry into the top bit (needed for `ovf`).
- The top level holds the FSM, the counter, the shift registers and the flag registers.

## Test plan
All scenarios use WIDTH=16 and DIGIT=4, so N=4.
1. **Add.** `start`, `sub=0`, a=0x1234, b=0x0FF0 → `busy` high for 4 cycles, then `done` pulse; `res`=0x2224, `cout`=0, `ovf`=0, `zero`=0.
2. **Signed overflow.** a=0x7FFF, b=0x0001, `sub=0` → `res`=0x8000, `ovf`=1, `cout`=0. Also a=0xFFFF, b=0x0001 → `res`=0x0000, `cout`=1, `zero`=1, `ovf`=0.
3. **Subtract with borrow, then equal operands.** a=0x0005, b=0x0007, `sub=1` → `res`=0xFFFE, `cout`=0, `ovf`=0. Then a=b=0x00AA, `sub=1` → `res`=0, `zero`=1, `cout`=1.
4. **Handshake edges.**
   - A `start` pulse with new operands in RUN cycle 2 is ignored, and the original result is produced.
   - `start` held high in the DONE cycle begins the next operation with no IDLE cycle; its `done` arrives 4 cycles later.
5. **Reset mid-operation.** Assert `rst` during RUN cycle 2 → next cycle all outputs are 0 and the state is IDLE; `done` never pulses. A fresh operation afterwards gives the correct result.
6. **Parameter sweep.** Random operands and mode against a behavioural reference, run for (WIDTH, DIGIT) = (8,1), (8,8), (32,4), (17,17) → all results and flags match, with latency equal to WIDTH/DIGIT.
